// File: rtl/twofish_round_sequencer.sv
// Control sequencer for one Twofish block: load, input whitening, Feistel rounds,
// output whitening, completion. Produces the subkey/whitening addresses for the key RAM.
module twofish_round_sequencer #(
    parameter int unsigned ROUNDS = 16,
    parameter int unsigned SKW    = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           decrypt,
    input  logic           kready,
    output logic           load_block,
    output logic           white_en,
    output logic [SKW-1:0] wk_base,
    output logic           round_en,
    output logic [3:0]     round_idx,
    output logic [SKW-1:0] sk_addr,
    output logic           last_round,
    output logic           busy,
    output logic           done,
    output logic           abort
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST_CNT = CW'(ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        IWHITE = 3'd2,
        ROUND  = 3'd3,
        OWHITE = 3'd4,
        DONE   = 3'd5
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           mode_q, mode_d;
    logic [CW-1:0]  sel_d;

    logic           load_block_q, load_block_d;
    logic           white_en_q, white_en_d;
    logic [SKW-1:0] wk_base_q, wk_base_d;
    logic           round_en_q, round_en_d;
    logic [CW-1:0]  round_idx_q, round_idx_d;
    logic [SKW-1:0] sk_addr_q, sk_addr_d;
    logic           last_round_q, last_round_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           abort_q, abort_d;

    // State, counter, latched mode and Moore outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            load_block_q <= 1'b0;
            white_en_q   <= 1'b0;
            wk_base_q    <= '0;
            round_en_q   <= 1'b0;
            round_idx_q  <= '0;
            sk_addr_q    <= '0;
            last_round_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            load_block_q <= load_block_d;
            white_en_q   <= white_en_d;
            wk_base_q    <= wk_base_d;
            round_en_q   <= round_en_d;
            round_idx_q  <= round_idx_d;
            sk_addr_q    <= sk_addr_d;
            last_round_q <= last_round_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
        end
    end

    // Next state; outputs are decoded from the next state so they register with it
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        abort_d      = 1'b0;
        sel_d        = '0;
        load_block_d = 1'b0;
        white_en_d   = 1'b0;
        wk_base_d    = '0;
        round_en_d   = 1'b0;
        round_idx_d  = '0;
        sk_addr_d    = '0;
        last_round_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && kready) begin
                    state_d = LOAD;
                    mode_d  = decrypt;
                end
            end
            LOAD:   state_d = IWHITE;
            IWHITE: begin
                state_d = ROUND;
                cnt_d   = '0;
            end
            ROUND: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = OWHITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OWHITE: state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Losing the key schedule kills the operation; DONE is already committed
        if (state_q != IDLE && state_q != DONE && !kready) begin
            state_d = IDLE;
            cnt_d   = '0;
            mode_d  = 1'b0;
            abort_d = 1'b1;
        end

        sel_d        = mode_d ? (LAST_CNT - cnt_d) : cnt_d;
        load_block_d = (state_d == LOAD);
        white_en_d   = (state_d == IWHITE) || (state_d == OWHITE);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        if (state_d == IWHITE) wk_base_d = mode_d ? SKW'(4) : SKW'(0);
        if (state_d == OWHITE) wk_base_d = mode_d ? SKW'(0) : SKW'(4);
        if (state_d == ROUND) begin
            round_en_d   = 1'b1;
            round_idx_d  = cnt_d;
            sk_addr_d    = SKW'(8) + SKW'({sel_d, 1'b0});
            last_round_d = (cnt_d == LAST_CNT);
        end
    end

    assign load_block = load_block_q;
    assign white_en   = white_en_q;
    assign wk_base    = wk_base_q;
    assign round_en   = round_en_q;
    assign round_idx  = round_idx_q;
    assign sk_addr    = sk_addr_q;
    assign last_round = last_round_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign abort      = abort_q;

endmodule

// File: tb/tb_twofish_round_sequencer.sv
// Directed bench for twofish_round_sequencer: a 16-round instance plus a 2-round build.
module tb_twofish_round_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, start2, decrypt, kready;

    logic       load_block, white_en, round_en, last_round, busy, done, abort;
    logic [5:0] wk_base, sk_addr;
    logic [3:0] round_idx;

    logic       load_block2, white_en2, round_en2, last_round2, busy2, done2, abort2;
    logic [5:0] wk_base2, sk_addr2;
    logic [3:0] round_idx2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    twofish_round_sequencer #(.ROUNDS(16), .SKW(6)) dut (
        .clk(clk), .reset(reset), .start(start), .decrypt(decrypt), .kready(kready),
        .load_block(load_block), .white_en(white_en), .wk_base(wk_base),
        .round_en(round_en), .round_idx(round_idx), .sk_addr(sk_addr),
        .last_round(last_round), .busy(busy), .done(done), .abort(abort)
    );

    twofish_round_sequencer #(.ROUNDS(2), .SKW(6)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .decrypt(decrypt), .kready(kready),
        .load_block(load_block2), .white_en(white_en2), .wk_base(wk_base2),
        .round_en(round_en2), .round_idx(round_idx2), .sk_addr(sk_addr2),
        .last_round(last_round2), .busy(busy2), .done(done2), .abort(abort2)
    );

    // {load_block, white_en, round_en, last_round, busy, done, abort}
    wire logic [6:0]  ctl   = {load_block, white_en, round_en, last_round, busy, done, abort};
    wire logic [6:0]  ctl2  = {load_block2, white_en2, round_en2, last_round2, busy2, done2, abort2};
    wire logic [22:0] all_o = {ctl, wk_base, round_idx, sk_addr};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full block on the 16-round instance; tog flips decrypt every round
    task automatic run_block(input logic dec, input logic tog, input string tag);
        logic [6:0] ectl;
        logic [5:0] esk;
        decrypt = dec;
        start   = 1'b1;
        step();
        start   = 1'b0;
        total++;
        if (ctl !== 7'b1000100) begin
            bad++; $display("FAIL %s_load ctl got=%b exp=%b", tag, ctl, 7'b1000100);
        end
        step();
        total++;
        if ({ctl, wk_base} !== {7'b0100100, (dec ? 6'd4 : 6'd0)}) begin
            bad++; $display("FAIL %s_iwhite ctl/wk got=%b/%0d exp_wk=%0d", tag, ctl, wk_base, dec ? 4 : 0);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            if (tog) decrypt = ~decrypt;
            ectl = (i == 15) ? 7'b0011100 : 7'b0010100;
            esk  = dec ? 6'(38 - 2 * i) : 6'(8 + 2 * i);
            total++;
            if ({ctl, round_idx, sk_addr} !== {ectl, 4'(i), esk}) begin
                bad++; $display("FAIL %s_round%0d ctl/idx/sk got=%b/%0d/%0d exp=%b/%0d/%0d",
                                tag, i, ctl, round_idx, sk_addr, ectl, i, esk);
            end
        end
        step();
        total++;
        if ({ctl, wk_base, sk_addr} !== {7'b0100100, (dec ? 6'd0 : 6'd4), 6'd0}) begin
            bad++; $display("FAIL %s_owhite ctl/wk/sk got=%b/%0d/%0d exp_wk=%0d", tag, ctl, wk_base, sk_addr, dec ? 0 : 4);
        end
        step();
        total++;
        if (ctl !== 7'b0000110) begin
            bad++; $display("FAIL %s_done ctl got=%b exp=%b", tag, ctl, 7'b0000110);
        end
        step();
        total++;
        if (all_o !== 23'd0) begin
            bad++; $display("FAIL %s_idle outputs got=%h exp=0", tag, all_o);
        end
        decrypt = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; start2 = 0; decrypt = 0; kready = 1;
        #12;
        total++;
        if ({all_o, ctl2} !== 30'd0) begin
            bad++; $display("FAIL reset_state outputs got=%h exp=0", {all_o, ctl2});
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        total++;
        if (all_o !== 23'd0) begin
            bad++; $display("FAIL reset_release outputs got=%h exp=0", all_o);
        end
    endtask

    task automatic test_reset_mid_round();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        total++;
        if ({round_en, round_idx} !== {1'b1, 4'd7}) begin
            bad++; $display("FAIL midrst_pre round_en/idx got=%b/%0d exp=1/7", round_en, round_idx);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (all_o !== 23'd0) begin
            bad++; $display("FAIL midrst_async outputs got=%h exp=0", all_o);
        end
        @(negedge clk);
        reset = 1'b0;
        run_block(1'b0, 1'b0, "post_rst");
    endtask

    task automatic test_encrypt();
        run_block(1'b0, 1'b0, "enc");
    endtask

    task automatic test_decrypt();
        run_block(1'b1, 1'b1, "dec");
    endtask

    task automatic test_no_kready();
        kready = 1'b0;
        start  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({load_block, busy, abort} !== 3'b000) begin
                bad++; $display("FAIL nokready_c%0d load/busy/abort got=%b exp=000", i, {load_block, busy, abort});
            end
        end
        start  = 1'b0;
        kready = 1'b1;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL nokready_after busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int loads;
        loads = 0;
        start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            step();
            if (load_block) loads++;
            if (c == 20) begin
                total++;
                if (done !== 1'b1) begin
                    bad++; $display("FAIL b2b_done c20 done got=%b exp=1", done);
                end
            end
            if (c == 21) begin
                total++;
                if ({busy, load_block} !== 2'b00) begin
                    bad++; $display("FAIL b2b_gap busy/load got=%b exp=00", {busy, load_block});
                end
            end
        end
        start = 1'b0;
        total++;
        if ({load_block, loads} !== {1'b1, 32'd2}) begin
            bad++; $display("FAIL b2b_second load/loads got=%b/%0d exp=1/2", load_block, loads);
        end
        repeat (22) step();
        total++;
        if (all_o !== 23'd0) begin
            bad++; $display("FAIL b2b_drain outputs got=%h exp=0", all_o);
        end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        total++;
        if (round_idx !== 4'd5) begin
            bad++; $display("FAIL abort_pre round_idx got=%0d exp=5", round_idx);
        end
        kready = 1'b0;
        step();
        total++;
        if (all_o !== {7'b0000001, 16'd0}) begin
            bad++; $display("FAIL abort_pulse outputs got=%h exp=%h", all_o, {7'b0000001, 16'd0});
        end
        for (int i = 0; i < 24; i++) begin
            step();
            if (done || abort || busy) dones++;
            if (i == 2) kready = 1'b1;
        end
        total++;
        if (dones !== 0) begin
            bad++; $display("FAIL abort_after done/abort/busy cycles got=%0d exp=0", dones);
        end
    endtask

    task automatic test_kready_in_done();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL kdone_done done got=%b exp=1", done);
        end
        kready = 1'b0;
        step();
        total++;
        if (ctl !== 7'd0) begin
            bad++; $display("FAIL kdone_no_abort ctl got=%b exp=0000000", ctl);
        end
        kready = 1'b1;
    endtask

    task automatic test_two_rounds();
        logic [6:0]  ec [6];
        logic [5:0]  es [6];
        logic [5:0]  ew [6];
        ec[0] = 7'b1000100; es[0] = 6'd0;  ew[0] = 6'd0;
        ec[1] = 7'b0100100; es[1] = 6'd0;  ew[1] = 6'd0;
        ec[2] = 7'b0010100; es[2] = 6'd8;  ew[2] = 6'd0;
        ec[3] = 7'b0011100; es[3] = 6'd10; ew[3] = 6'd0;
        ec[4] = 7'b0100100; es[4] = 6'd0;  ew[4] = 6'd4;
        ec[5] = 7'b0000110; es[5] = 6'd0;  ew[5] = 6'd0;
        decrypt = 1'b0;
        start2  = 1'b1;
        step();
        start2  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            total++;
            if ({ctl2, sk_addr2, wk_base2} !== {ec[c], es[c], ew[c]}) begin
                bad++; $display("FAIL r2_c%0d ctl/sk/wk got=%b/%0d/%0d exp=%b/%0d/%0d",
                                c + 1, ctl2, sk_addr2, wk_base2, ec[c], es[c], ew[c]);
            end
        end
        step();
        total++;
        if (ctl2 !== 7'd0) begin
            bad++; $display("FAIL r2_idle ctl got=%b exp=0000000", ctl2);
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_reset_mid_round();
        test_no_kready();
        test_back_to_back();
        test_abort();
        test_kready_in_done();
        test_two_rounds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
